speck_iter_core: RTL
====================

SPECK_ITER_CORE -- requirements
Module: speck_iter_core

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter WORD_W, default 64, word width n; SHALL support 48 (SPECK96/96) and 64 (SPECK128/128).
REQ-003 Parameter NR_ROUNDS, default 32, round count; SHALL support 2..64 (28 for WORD_W=48).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 mode  input  1  0=encrypt, 1=decrypt; sampled with start.
REQ-008 reuse_key  input  1  1=skip key expansion and use the stored round keys; sampled with start.
REQ-009 key  input  2*WORD_W  k0=key[2W-1:W], l0=key[W-1:0].
REQ-010 data_in  input  2*WORD_W  x=[2W-1:W], y=[W-1:0].
REQ-011 data_out  output  2*WORD_W  result registered; same word layout as data_in.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 finished  output  1  one-cycle completion pulse.
REQ-014 state_response  output  4  current state encoding: IDLE=0, EXPAND=1, ROUND=2, DONE=3.

Function
REQ-015 Rotations SHALL be fixed: alpha=8 and beta=3; all arithmetic SHALL be modulo 2^WORD_W.
REQ-016 Key step i SHALL compute l'=(k+ROR(l,8))^i and k'=ROL(k,3)^l'.
REQ-017 The encrypt round SHALL compute x'=(ROR(x,8)+y)^rk and y'=ROL(y,3)^x'.
REQ-018 The decrypt round SHALL compute y'=ROR(x^y,3) and x'=ROL((x^rk)-y',8).
REQ-019 The block SHALL hold a round-key array rk[0..NR_ROUNDS-1] and a key_valid flag.
REQ-020 IDLE with start=1 SHALL capture data_in, mode, k0, l0, write rk[0]=k0, and clear ctr.
REQ-021 From that capture, the next state SHALL be ROUND if reuse_key=1 and key_valid=1, otherwise EXPAND.
REQ-022 In a reuse capture, key SHALL be ignored and rk SHALL be left unchanged.
REQ-023 EXPAND SHALL perform one key step per cycle with i=ctr and write rk[ctr+1]=k'.
REQ-024 EXPAND SHALL last NR_ROUNDS-1 cycles, then set key_valid=1, set ctr=0, and go to ROUND.
REQ-025 ROUND SHALL perform one round per cycle using rk[ctr] for encrypt or rk[NR_ROUNDS-1-ctr] for decrypt.
REQ-026 ROUND SHALL last NR_ROUNDS cycles, then load data_out and go to DONE.
REQ-027 DONE SHALL assert finished=1 for exactly one cycle, then return to IDLE.
REQ-028 Latency from the start-sampling edge to finished high SHALL be 2*NR_ROUNDS cycles with expansion, or NR_ROUNDS+1 cycles with reuse.
REQ-029 start SHALL be ignored while busy=1; start held high SHALL begin a new operation in the first IDLE cycle after DONE.
REQ-030 Changes on key, data_in, mode or reuse_key after capture SHALL NOT affect the operation in progress.
REQ-031 data_out SHALL hold its value until the next entry to DONE.
REQ-032 Back-to-back operations with reuse_key=1 SHALL be limited only by the one IDLE cycle between operations.
REQ-033 ctr SHALL be ceil(log2(NR_ROUNDS)) bits wide and SHALL NOT wrap within a state.

Reset
REQ-034 When rst_n=0, the block SHALL immediately set state=IDLE, ctr=0, key_valid=0, data_out=0, busy=0, finished=0 and state_response=0.
REQ-035 rk contents SHALL be don't-care after reset.
REQ-036 Reset in EXPAND or ROUND SHALL abort the operation with no finished pulse.
REQ-037 The first start after reset SHALL always expand, even if reuse_key=1.

Verification
REQ-038 Encrypt test: W=64, R=32, key=0706050403020100_0f0e0d0c0b0a0908, data_in=6c61766975716520_7469206564616d20 -> data_out=a65d985179783265_7860fedf5c570d18, finished 64 cycles after start.
REQ-039 Decrypt test: same key, mode=1, reuse_key=1, data_in=a65d985179783265_7860fedf5c570d18 -> data_out=6c61766975716520_7469206564616d20, finished 33 cycles after start.
REQ-040 W=48 test: R=28, key=050403020100_0d0c0b0a0908, data_in=65776f68202c_656761737520 -> data_out=9e4d09ab7178_62bdde8f79aa.
REQ-041 Busy test: start pulses during EXPAND and ROUND -> ignored, exactly one finished pulse, data_out unchanged mid-run.
REQ-042 Reset test: rst_n=0 at ROUND ctr=10 -> all outputs 0 immediately; next start with reuse_key=1 -> enters EXPAND (key_valid=0).
REQ-043 Random test: 1000 random keys and blocks, encrypt then decrypt -> round trip equals the input; results match a software model.

Source files
------------

// File: rtl/speck_iter_core.sv
// Iterative SPECK block cipher core (SPECK96/96, SPECK128/128 and similar m=2 variants).
// One key-schedule step or one cipher round per clock. Round keys are kept in a local
// array so later operations under the same key can skip key expansion.
module speck_iter_core #(
  parameter int unsigned WORD_W    = 64,
  parameter int unsigned NR_ROUNDS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  reuse_key,
  input  logic [2*WORD_W-1:0]   key,
  input  logic [2*WORD_W-1:0]   data_in,
  output logic [2*WORD_W-1:0]   data_out,
  output logic                  busy,
  output logic                  finished,
  output logic [3:0]            state_response
);

  localparam int unsigned CtrW = $clog2(NR_ROUNDS);
  // Last counter value of each phase; the counter never wraps inside a state.
  localparam logic [CtrW-1:0] LastExp = CtrW'(NR_ROUNDS - 2);
  localparam logic [CtrW-1:0] LastRnd = CtrW'(NR_ROUNDS - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExpand = 2'd1,
    StRound  = 2'd2,
    StDone   = 2'd3
  } state_e;

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int unsigned s);
    return (v >> s) | (v << (WORD_W - s));
  endfunction

  function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input int unsigned s);
    return (v << s) | (v >> (WORD_W - s));
  endfunction

  state_e              state_q, state_d;
  logic [CtrW-1:0]     ctr_q, ctr_d;
  logic                key_valid_q, key_valid_d;
  logic                mode_q, mode_d;
  logic [WORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [WORD_W-1:0]   k_q, k_d, l_q, l_d;
  logic [2*WORD_W-1:0] dout_q, dout_d;

  logic [WORD_W-1:0]   rk_q [NR_ROUNDS];
  logic                rk_we;
  logic [CtrW-1:0]     rk_waddr;
  logic [WORD_W-1:0]   rk_wdata;

  logic [CtrW-1:0]     rk_idx;
  logic [WORD_W-1:0]   rk_cur;
  logic [WORD_W-1:0]   l_step, k_step;
  logic [WORD_W-1:0]   enc_x, enc_y, dec_x, dec_y, rnd_x, rnd_y;

  // Key schedule step: iteration index is the counter itself.
  assign l_step = (k_q + ror(l_q, 8)) ^ WORD_W'(ctr_q);
  assign k_step = rol(k_q, 3) ^ l_step;

  // Decryption walks the round keys backwards.
  assign rk_idx = mode_q ? (LastRnd - ctr_q) : ctr_q;
  assign rk_cur = rk_q[rk_idx];

  assign enc_x = (ror(x_q, 8) + y_q) ^ rk_cur;
  assign enc_y = rol(y_q, 3) ^ enc_x;
  assign dec_y = ror(x_q ^ y_q, 3);
  assign dec_x = rol((x_q ^ rk_cur) - dec_y, 8);
  assign rnd_x = mode_q ? dec_x : enc_x;
  assign rnd_y = mode_q ? dec_y : enc_y;

  // Next-state, datapath updates and round-key write port.
  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    key_valid_d = key_valid_q;
    mode_d      = mode_q;
    x_d         = x_q;
    y_d         = y_q;
    k_d         = k_q;
    l_d         = l_q;
    dout_d      = dout_q;
    rk_we       = 1'b0;
    rk_waddr    = '0;
    rk_wdata    = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d    = data_in[2*WORD_W-1:WORD_W];
          y_d    = data_in[WORD_W-1:0];
          mode_d = mode;
          ctr_d  = '0;
          if (reuse_key && key_valid_q) begin
            state_d = StRound;
          end else begin
            k_d      = key[2*WORD_W-1:WORD_W];
            l_d      = key[WORD_W-1:0];
            rk_we    = 1'b1;
            rk_waddr = '0;
            rk_wdata = key[2*WORD_W-1:WORD_W];
            state_d  = StExpand;
          end
        end
      end
      StExpand: begin
        k_d      = k_step;
        l_d      = l_step;
        rk_we    = 1'b1;
        rk_waddr = ctr_q + CtrW'(1);
        rk_wdata = k_step;
        if (ctr_q == LastExp) begin
          ctr_d       = '0;
          key_valid_d = 1'b1;
          state_d     = StRound;
        end else begin
          ctr_d = ctr_q + CtrW'(1);
        end
      end
      StRound: begin
        x_d = rnd_x;
        y_d = rnd_y;
        if (ctr_q == LastRnd) begin
          dout_d  = {rnd_x, rnd_y};
          ctr_d   = '0;
          state_d = StDone;
        end else begin
          ctr_d = ctr_q + CtrW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ctr_q       <= '0;
      key_valid_q <= 1'b0;
      mode_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      k_q         <= '0;
      l_q         <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      key_valid_q <= key_valid_d;
      mode_q      <= mode_d;
      x_q         <= x_d;
      y_q         <= y_d;
      k_q         <= k_d;
      l_q         <= l_d;
      dout_q      <= dout_d;
    end
  end

  // Round-key storage; contents are meaningless until key_valid is set, so no reset.
  always_ff @(posedge clk) begin
    if (rk_we) begin
      rk_q[rk_waddr] <= rk_wdata;
    end
  end

  assign data_out       = dout_q;
  assign busy           = (state_q != StIdle);
  assign finished       = (state_q == StDone);
  assign state_response = {2'b00, state_q};

endmodule
